// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with divider start/annul sequencing
// Merges stage stall requests, drives redirect on exceptions, and counts stalled cycles.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h00000020,
    parameter logic [31:0] ERET_CODE   = 32'h0000000e,
    parameter int          DIV_TIMEOUT = 40,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             div_req_i,
    input  logic             div_ready_i,
    output logic             div_start_o,
    output logic             div_annul_o,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } div_state_t;

    localparam int TW = $clog2(DIV_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 1);

    div_state_t    state;
    logic [TW-1:0] tmo_cnt;
    logic          exc;
    logic          div_stall;

    // Outputs are gated by rst so they fall to zero the moment reset asserts,
    // even while stall requests are still present on the inputs.
    always_comb begin
        exc       = (excepttype_i != 32'd0);
        div_stall = (state == START) || (state == WAIT) ||
                    ((state == IDLE) && div_req_i);
        flush     = 1'b0;
        new_pc    = 32'd0;
        stall     = 6'b000000;
        if (!rst) begin
            if (exc) begin
                flush  = 1'b1;
                new_pc = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex || div_stall) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end else if (stallreq_if) begin
                stall = 6'b000011;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            div_start_o <= 1'b0;
            div_annul_o <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            div_start_o <= 1'b0;
            div_annul_o <= 1'b0;
            if ((stall != 6'b000000) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (div_req_i && !flush) begin
                        state       <= START;
                        div_start_o <= 1'b1;
                    end
                end
                START: begin
                    tmo_cnt <= '0;
                    if (flush) begin
                        state       <= ABORT;
                        div_annul_o <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A flush beats a coincident ready: the result belongs to a squashed instruction.
                    if (flush || (!div_ready_i && (tmo_cnt == TMO_LAST))) begin
                        state       <= ABORT;
                        div_annul_o <= 1'b1;
                        tmo_cnt     <= '0;
                    end else if (div_ready_i) begin
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ABORT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized checks of pipe_ctrl against a cycle-count model
module tb_pipe_ctrl;

    localparam int TO = 40;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0]   excepttype;
    logic [31:0]   cp0_epc;
    logic          div_req, div_ready;
    logic          div_start_o, div_annul_o;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic [CW-1:0] stall_cnt;

    pipe_ctrl #(
        .EXC_VECTOR (32'h00000020),
        .ERET_CODE  (32'h0000000e),
        .DIV_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .excepttype_i(excepttype),
        .cp0_epc_i   (cp0_epc),
        .div_req_i   (div_req),
        .div_ready_i (div_ready),
        .div_start_o (div_start_o),
        .div_annul_o (div_annul_o),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: m_t = cycles since the divide was accepted (-1 when no divide is
    // in flight, 0 = start cycle, t>=1 = waiting cycle t-1); m_post marks the
    // single cycle after completion (1 = finished normally, 2 = annulled).
    int m_t    = -1;
    int m_post = 0;
    int m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle_inputs();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        excepttype   = 32'd0;
        cp0_epc      = 32'd0;
        div_req      = 1'b0;
        div_ready    = 1'b0;
    endtask

    task automatic model_reset();
        m_t    = -1;
        m_post = 0;
        m_cnt  = 0;
    endtask

    // Called at posedge+1 with inputs already applied; checks at negedge, then advances.
    task automatic cycle();
        logic        exc;
        logic        dstall;
        logic [5:0]  es;
        logic [31:0] epc;
        exc    = (excepttype != 32'd0);
        dstall = (m_t >= 0) || (m_t < 0 && m_post == 0 && div_req);
        if (exc)                          es = 6'h00;
        else if (stallreq_mem)            es = 6'h1f;
        else if (stallreq_ex || dstall)   es = 6'h0f;
        else if (stallreq_id)             es = 6'h07;
        else if (stallreq_if)             es = 6'h03;
        else                              es = 6'h00;
        epc = !exc ? 32'd0 : ((excepttype == 32'he) ? cp0_epc : 32'h20);
        @(negedge clk);
        chk("stall", 32'(stall), 32'(es));
        chk("flush", 32'(flush), 32'(exc));
        chk("new_pc", new_pc, epc);
        chk("div_start", 32'(div_start_o), 32'(m_t == 0));
        chk("div_annul", 32'(div_annul_o), 32'(m_post == 2));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (es != 6'h00 && m_cnt < CNT_MAX) m_cnt++;
        if (m_t >= 0) begin
            if (exc) begin
                m_t = -1; m_post = 2;
            end else if (m_t == 0) begin
                m_t = 1;
            end else if (div_ready) begin
                m_t = -1; m_post = 1;
            end else if (m_t - 1 == TO - 1) begin
                m_t = -1; m_post = 2;
            end else begin
                m_t++;
            end
        end else if (m_post != 0) begin
            m_post = 0;
        end else if (div_req && !exc) begin
            m_t = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int annul_seen;
        set_idle_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_cnt", 32'(stall_cnt), 32'h0);
        chk("reset_start", 32'(div_start_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stall counter and saturation
        stallreq_if = 1'b1;
        for (int c = 0; c < 7; c++) cycle();
        stallreq_if = 1'b0;
        #1;
        chk("cnt_seven", 32'(stall_cnt), 32'd7);
        for (int c = 0; c < 12; c++) begin
            stallreq_id = c[0];
            stallreq_ex = c[1];
            cycle();
        end
        set_idle_inputs();
        stallreq_if = 1'b1;
        for (int c = 0; c < 10; c++) cycle();
        stallreq_if = 1'b0;
        #1;
        chk("cnt_saturate", 32'(stall_cnt), CNT_MAX);

        // Priority
        stallreq_if = 1'b1;
        stallreq_id = 1'b1;
        #1;
        chk("prio_id", 32'(stall), 32'h07);
        cycle();
        stallreq_mem = 1'b1;
        #1;
        chk("prio_mem", 32'(stall), 32'h1f);
        cycle();

        // Exception overrides stall requests
        excepttype = 32'h8;
        #1;
        chk("exc_stall", 32'(stall), 32'h0);
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_pc", new_pc, 32'h20);
        cycle();
        excepttype = 32'he;
        cp0_epc    = 32'hBFC00100;
        #1;
        chk("eret_pc", new_pc, 32'hBFC00100);
        cycle();
        set_idle_inputs();
        cycle();

        // Divide completing with ready at cycle 35
        for (int c = 0; c < 38; c++) begin
            div_req   = (c <= 36);
            div_ready = (c == 35);
            #1;
            if (c == 0)  chk("div_stall_c0", 32'(stall), 32'h0f);
            if (c == 1)  chk("div_start_c1", 32'(div_start_o), 32'h1);
            if (c == 2)  chk("div_start_c2", 32'(div_start_o), 32'h0);
            if (c == 36) chk("div_done_c36", 32'(stall), 32'h0);
            cycle();
        end
        set_idle_inputs();
        cycle();

        // Timeout without ready
        annul_seen = 0;
        for (int c = 0; c < 45; c++) begin
            div_req = (c <= 42);
            #1;
            if (div_annul_o) annul_seen++;
            if (c == 42) chk("tmo_annul_c42", 32'(div_annul_o), 32'h1);
            if (c == 43) chk("tmo_release", 32'(stall), 32'h0);
            cycle();
        end
        chk("tmo_annul_once", annul_seen, 32'd1);
        set_idle_inputs();
        cycle();

        // Flush coincident with ready at WAIT cycle 10
        for (int c = 0; c < 16; c++) begin
            div_req    = (c <= 12);
            div_ready  = (c == 12);
            excepttype = (c == 12) ? 32'h1 : 32'h0;
            #1;
            if (c == 13) chk("flush_annul", 32'(div_annul_o), 32'h1);
            if (c == 14) chk("flush_annul_off", 32'(div_annul_o), 32'h0);
            cycle();
        end
        set_idle_inputs();

        // Asynchronous reset during WAIT
        div_req      = 1'b1;
        stallreq_mem = 1'b1;
        for (int c = 0; c < 6; c++) cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stall", 32'(stall), 32'h0);
        chk("arst_cnt", 32'(stall_cnt), 32'h0);
        chk("arst_start", 32'(div_start_o), 32'h0);
        chk("arst_annul", 32'(div_annul_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        set_idle_inputs();
        cycle();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            stallreq_if  = ($urandom_range(0, 3) == 0);
            stallreq_id  = ($urandom_range(0, 5) == 0);
            stallreq_ex  = ($urandom_range(0, 7) == 0);
            stallreq_mem = ($urandom_range(0, 7) == 0);
            div_req      = ($urandom_range(0, 1) == 0);
            div_ready    = ($urandom_range(0, 15) == 0);
            cp0_epc      = $urandom;
            case ($urandom_range(0, 23))
                0:       excepttype = 32'he;
                1:       excepttype = $urandom | 32'h1;
                default: excepttype = 32'd0;
            endcase
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It merges stall requests from IF/ID/EX/MEM into the stall[5:0] vector consumed by every stage register (pc, if_id, id_ex, ex_mem, mem_wb). It sequences the multi-cycle divider through a start/ready/annul handshake, with an EX stall held for the duration. On an exception it raises a flush and supplies the redirect PC.

Parameters:
EXC_VECTOR, 32'h00000020, redirect PC for every non-ERET exception
ERET_CODE, 32'h0000000e, excepttype_i value meaning ERET (redirect to EPC)
DIV_TIMEOUT, 40, max cycles in WAIT before forced annul
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
stallreq_if  in  1  fetch bus not ready
stallreq_id  in  1  load-use hazard from decode
stallreq_ex  in  1  EX-internal multi-cycle op (non-div)
stallreq_mem  in  1  data bus not ready
excepttype_i  in  32  from MEM; nonzero = exception this cycle
cp0_epc_i  in  32  current EPC
div_req_i  in  1  EX holds a DIV/DIVU this cycle
div_ready_i  in  1  divider result valid (one-cycle pulse)
div_start_o  out  1  divider start pulse
div_annul_o  out  1  divider abort pulse
stall  out  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold
flush  out  1  clear all stage registers
new_pc  out  32  redirect target, valid when flush=1
stall_cnt  out  CNT_W  saturating count of cycles with stall!=0

Behaviour:
- Reset (async, rst=1): stall=0, flush=0, new_pc=0, div_start_o=0, div_annul_o=0, stall_cnt=0, FSM=IDLE.
- stall, flush, and new_pc are combinational from the current inputs and FSM state. div_start_o and div_annul_o are decoded from the FSM state.
- Exception: excepttype_i!=0 -> flush=1 and stall=6'b000000, overriding every stall request.
  - new_pc = cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR.
  - When flush=0, new_pc=0.
- Stall priority, highest first, when there is no exception:
  - stallreq_mem -> 6'b011111
  - stallreq_ex or div_stall -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - none -> 6'b000000
- div_stall=1 in states START and WAIT, and in IDLE when div_req_i=1.
- Divider FSM states: IDLE, START, WAIT, DONE, ABORT.
  - IDLE: div_req_i=1 and flush=0 -> START.
  - START: div_start_o=1 for exactly one cycle; load timeout counter=0 -> WAIT.
  - WAIT: counter increments each cycle.
    - div_ready_i=1 -> DONE.
    - else counter==DIV_TIMEOUT-1 -> ABORT.
  - DONE: div_stall=0 for one cycle so the instruction advances; the divider result is consumed by EX -> IDLE. A new div_req_i is not accepted in DONE.
  - ABORT: div_annul_o=1 for one cycle -> IDLE. div_stall stays 0, and the pipeline proceeds with an undefined result.
- Flush mid-operation: if flush=1 while in START or WAIT -> next state ABORT (annul pulse), and the timeout counter is cleared.
  - If flush=1 in the same cycle as div_ready_i in WAIT, flush wins -> ABORT.
- div_ready_i outside WAIT is ignored.
- stall_cnt increments when stall!=0 and saturates at all-ones. It is cleared only by reset.
- rst asserted in any state -> IDLE immediately. Outputs drop to reset values without waiting for a clock edge.

Test Plan:
- Priority: stallreq_if=1, stallreq_id=1, all others 0 -> stall=6'b000111; then stallreq_mem=1 -> stall=6'b011111.
- Exception overrides stall: stallreq_mem=1 with excepttype_i=32'h8 -> stall=0, flush=1, new_pc=32'h20. With excepttype_i=32'he and cp0_epc_i=32'hBFC00100 -> new_pc=32'hBFC00100.
- Divide: div_req_i=1 at cycle 0 -> stall=6'b001111 from cycle 0; div_start_o=1 at cycle 1 only. div_ready_i at cycle 35 -> DONE at cycle 36 with stall=0, then IDLE.
- Timeout: div_req_i with div_ready_i never asserted -> div_annul_o pulses exactly once, 40 cycles after START, then stall releases.
- Flush mid-divide: excepttype_i=1 at WAIT cycle 10, coincident with div_ready_i=1 -> ABORT next cycle, div_annul_o=1 for one cycle, no DONE.
- Reset/counter: 7 stalled cycles -> stall_cnt=7. Asserting rst asynchronously mid-WAIT -> outputs 0 before the next clk edge, stall_cnt=0.
